// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through sequencer for the dual-port packet RAM: owns the
// write/read pointers and hides the RAM's registered read behind out_valid.
module ram_fifo_ctrl #(
    parameter int packetwidth  = 55,
    parameter int addressWidth = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    ram_writeEn,
    output logic [addressWidth-1:0] ram_writeAddr,
    output logic                    ram_readEn,
    output logic [addressWidth-1:0] ram_readAddr,
    output logic [addressWidth:0]   count,
    output logic                    empty,
    output logic                    full
);

    localparam int DEPTH = 1 << addressWidth;
    localparam logic [addressWidth:0] DEPTH_CNT = (addressWidth + 1)'(DEPTH);

    if (addressWidth < 1 || packetwidth < 1) begin : g_paramCheck
        $error("ram_fifo_ctrl: addressWidth and packetwidth must be >= 1");
    end

    typedef enum logic {
        HEAD_EMPTY = 1'b0,
        HEAD_FULL  = 1'b1
    } headState_t;

    headState_t              stateReg, stateNext;
    logic [addressWidth-1:0] wrPtrReg, rdPtrReg;
    logic [addressWidth:0]   ramCntReg, ramCntNext;
    logic                    active, wrFire, rdFire, ramHasData;

    // Flush in either form suppresses RAM strobes so in-flight traffic is dropped.
    assign active     = reset & ~clear;
    assign ramHasData = (ramCntReg != '0);

    assign in_ready      = (ramCntReg != DEPTH_CNT);
    assign wrFire        = active & in_valid & in_ready;
    assign ram_writeEn   = wrFire;
    assign ram_writeAddr = wrPtrReg;
    assign ram_readAddr  = rdPtrReg;
    assign ram_readEn    = rdFire;

    assign count = ramCntReg + {{addressWidth{1'b0}}, out_valid};
    assign empty = (count == '0);
    assign full  = ~in_ready;

    // State register plus datapath registers.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            stateReg  <= HEAD_EMPTY;
            wrPtrReg  <= '0;
            rdPtrReg  <= '0;
            ramCntReg <= '0;
        end else begin
            stateReg  <= stateNext;
            ramCntReg <= ramCntNext;
            if (wrFire) begin
                wrPtrReg <= wrPtrReg + 1'b1;
            end
            if (rdFire) begin
                rdPtrReg <= rdPtrReg + 1'b1;
            end
        end
    end

    // Next-state logic for the head slot.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            HEAD_EMPTY: if (ramHasData) stateNext = HEAD_FULL;
            HEAD_FULL:  if (out_ready && !ramHasData) stateNext = HEAD_EMPTY;
            default:    stateNext = HEAD_EMPTY;
        endcase
    end

    // Eligibility uses the registered count, so a read never hits this cycle's write address.
    always_comb begin
        rdFire    = 1'b0;
        out_valid = (stateReg == HEAD_FULL);
        case (stateReg)
            HEAD_EMPTY: rdFire = active & ramHasData;
            HEAD_FULL:  rdFire = active & out_ready & ramHasData;
            default:    rdFire = 1'b0;
        endcase
    end

    always_comb begin
        ramCntNext = ramCntReg;
        case ({wrFire, rdFire})
            2'b10:   ramCntNext = ramCntReg + 1'b1;
            2'b01:   ramCntNext = ramCntReg - 1'b1;
            default: ramCntNext = ramCntReg;
        endcase
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural packet RAM and an
// in-order scoreboard on the head packet.
module tb_ram_fifo_ctrl;

    localparam int PW = 55;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset, clear, in_valid, out_ready;
    logic          in_ready, out_valid, ram_writeEn, ram_readEn, empty, full;
    logic [AW-1:0] ram_writeAddr, ram_readAddr;
    logic [AW:0]   count;

    logic [PW-1:0] dataIn;
    logic [PW-1:0] ramDataOut;
    logic [PW-1:0] mem [0:(1<<AW)-1];
    logic [PW-1:0] expQ [$];
    logic [PW-1:0] seq;

    logic          lastWriteEn, lastReadEn;
    logic [AW-1:0] lastWriteAddr, lastReadAddr;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.packetwidth(PW), .addressWidth(AW)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .ram_writeEn(ram_writeEn), .ram_writeAddr(ram_writeAddr),
        .ram_readEn(ram_readEn), .ram_readAddr(ram_readAddr),
        .count(count), .empty(empty), .full(full)
    );

    always @(posedge clk) begin
        if (ram_writeEn) mem[ram_writeAddr] <= dataIn;
        if (ram_readEn)  ramDataOut <= mem[ram_readAddr];
    end

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs just after a falling edge, sample strobes, then
    // return at the next falling edge with registered outputs settled.
    task automatic cycle(input logic rstN, input logic clr, input logic iv, input logic ordy);
        reset = rstN; clear = clr; in_valid = iv; out_ready = ordy;
        dataIn = seq; seq = seq + 1;
        #1;
        lastWriteEn = ram_writeEn; lastWriteAddr = ram_writeAddr;
        lastReadEn  = ram_readEn;  lastReadAddr  = ram_readAddr;
        if (ram_readEn && ram_writeEn)
            checkValue("raw_hazard", 64'(ram_readAddr == ram_writeAddr), 64'd0);
        if (rstN && !clr && out_valid && !ordy)
            checkValue("hold_no_read", 64'(ram_readEn), 64'd0);
        if (rstN && !clr && out_valid && ordy) begin
            if (expQ.size() == 0) checkValue("sb_empty_pop", 64'(out_valid), 64'd0);
            else                  checkValue("sb_data", 64'(ramDataOut), 64'(expQ.pop_front()));
        end
        if (ram_writeEn) expQ.push_back(dataIn);
        @(posedge clk);
        if (!rstN || clr) expQ.delete();
        @(negedge clk);
        $display("cyc rst=%0b clr=%0b iv=%0b ordy=%0b we=%0b wa=%0d re=%0b ra=%0d ov=%0b cnt=%0d",
                 rstN, clr, iv, ordy, lastWriteEn, lastWriteAddr, lastReadEn, lastReadAddr,
                 out_valid, count);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (empty) break;
            cycle(1'b1, 1'b0, 1'b0, 1'b1);
        end
        checkValue("drain_empty", 64'(empty), 64'd1);
        checkValue("drain_sb", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        seq = 55'h100; dataIn = '0;
        reset = 1'b0; clear = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);

        // 1. Reset held with in_valid asserted
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            checkValue("rst_no_write", 64'(lastWriteEn), 64'd0);
        end
        checkValue("rst_in_ready", 64'(in_ready), 64'd1);
        checkValue("rst_out_valid", 64'(out_valid), 64'd0);
        checkValue("rst_count", 64'(count), 64'd0);
        checkValue("rst_empty", 64'(empty), 64'd1);
        checkValue("rst_full", 64'(full), 64'd0);

        // 2. Single packet, latency and hold
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        checkValue("single_we", 64'(lastWriteEn), 64'd1);
        checkValue("single_wa", 64'(lastWriteAddr), 64'd0);
        checkValue("single_ov_early", 64'(out_valid), 64'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        checkValue("single_re", 64'(lastReadEn), 64'd1);
        checkValue("single_ra", 64'(lastReadAddr), 64'd0);
        checkValue("single_ov", 64'(out_valid), 64'd1);
        checkValue("single_count", 64'(count), 64'd1);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            checkValue("single_hold_re", 64'(lastReadEn), 64'd0);
            checkValue("single_hold_ov", 64'(out_valid), 64'd1);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        checkValue("single_pop_ov", 64'(out_valid), 64'd0);
        checkValue("single_pop_empty", 64'(empty), 64'd1);

        // 3. Fill to DEPTH+1 with no consumer
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0);
            checkValue("fill_we", 64'(lastWriteEn), 64'd1);
        end
        checkValue("fill_full", 64'(full), 64'd1);
        checkValue("fill_in_ready", 64'(in_ready), 64'd0);
        checkValue("fill_count", 64'(count), 64'd17);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        checkValue("fill_18th_we", 64'(lastWriteEn), 64'd0);
        checkValue("fill_18th_count", 64'(count), 64'd17);
        drain();

        // 4. Streaming at one packet per cycle across pointer wrap
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b1);
            checkValue("stream_we", 64'(lastWriteEn), 64'd1);
            if (i >= 1) checkValue("stream_re", 64'(lastReadEn), 64'd1);
        end
        checkValue("stream_count", 64'(count), 64'd2);
        drain();

        // 5. Random backpressure
        for (int i = 0; i < 60; i++)
            cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain();

        // 6. Clear with packets queued
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        checkValue("clr_pre_count", 64'(count), 64'd5);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        checkValue("clr_we", 64'(lastWriteEn), 64'd0);
        checkValue("clr_re", 64'(lastReadEn), 64'd0);
        checkValue("clr_count", 64'(count), 64'd0);
        checkValue("clr_ov", 64'(out_valid), 64'd0);
        checkValue("clr_empty", 64'(empty), 64'd1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        checkValue("clr_wa", 64'(lastWriteAddr), 64'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        checkValue("clr_re_after", 64'(lastReadEn), 64'd1);
        checkValue("clr_ra", 64'(lastReadAddr), 64'd0);
        checkValue("clr_ov_after", 64'(out_valid), 64'd1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
